team_08_gpio_arbiter: RTL and testbench
=======================================

Name: team_08_gpio_arbiter

Overview:
- Shares the 34-bit team GPIO output bus between up to NREQ on-chip requesters, e.g. the game core, a seven-segment/LED test-pattern generator and a debug dumper.
- Grants are round-robin with a req/gnt handshake, a registered pin drive and a one-cycle turnaround between owners.
- Also provides a 2-flop synchronised copy of the GPIO input bus to all requesters.
- Sits between the requesters and the GPIO pin wrapper.

Parameters:
- NREQ, 4, number of requesters (1..8).
- WIDTH, 34, GPIO bus width.
- IDLE_VAL, 34'd0, pin value driven when no requester owns the bus.
- MAX_HOLD, 1024, cycles an owner may hold the bus before preemption (timeout feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held high for the whole ownership.
- req_data  in  NREQ*WIDTH  packed pin words; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, registered.
- owner  out  $clog2(NREQ) (min 1)  index of current or last owner.
- busy  out  1  high while in GRANT.
- preempted  out  1  one-cycle pulse when the owner is forcibly released.
- gpio_out  out  WIDTH  registered pin word to the GPIO wrapper.
- gpio_in  in  WIDTH  raw pin inputs.
- in_sync  out  WIDTH  gpio_in after a 2-flop synchroniser.

Behaviour:
- Reset (async, reset=0) values:
  - State IDLE.
  - gnt=0, busy=0, preempted=0, owner=0, gpio_out=IDLE_VAL.
  - rr pointer=0 (requester 0 has highest priority first).
  - hold_cnt=0.
  - Synchroniser flops=0.
  - A reset asserted mid-ownership takes effect immediately, with no turnaround.
- FSM states: IDLE, GRANT, TURN.
- Pick function: the first i with req[i]=1, searching from the rr pointer upward with wrap NREQ-1→0. Combinational on the current req only; a requester that drops req before its grant is never granted.
- IDLE:
  - If any req, go to GRANT next edge.
  - On that edge: gnt[pick]=1, owner=pick, busy=1, hold_cnt=0.
  - Otherwise stay; gpio_out=IDLE_VAL.
- GRANT:
  - gpio_out <= req_data[owner] every cycle, i.e. 1-cycle latency from req_data to the pins.
  - The first owner word reaches the pins one cycle after gnt rises.
  - hold_cnt increments and saturates at MAX_HOLD-1.
- Release, when req[owner]=0 in GRANT:
  - Next edge: state TURN, gnt=0, busy=0, gpio_out=IDLE_VAL.
  - rr pointer = (owner+1) mod NREQ.
- Preempt (feature enabled only):
  - Condition: hold_cnt==MAX_HOLD-1 and req[owner]=1 and some other req[j]=1.
  - Same transition as release, plus preempted=1 for exactly that one cycle.
  - If req[owner] drops in the same cycle, it is a release and preempted stays 0.
  - If no other requester is active, the owner keeps the bus; hold_cnt stays saturated.
- TURN:
  - Exactly one cycle; gnt=0, gpio_out=IDLE_VAL.
  - Arbitrates as IDLE does: any req → GRANT next edge, else → IDLE.
  - The gap between owners is therefore exactly one gnt-low cycle.
- owner holds its value outside GRANT.
- Invariants: gnt is always one-hot or zero; gnt is never high in TURN.
- NREQ=1: the pointer is constant 0; release/turnaround behaviour is unchanged.
- in_sync has a 2-cycle latency and is independent of the FSM.

Optional Feature:
- Macro: TEAM08_GPIO_ARB_TIMEOUT_EN.
- Defined: hold_cnt and MAX_HOLD preemption as described; preempted is driven.
- Undefined: no counter; an owner keeps the bus until it drops req; preempted is tied to 0; MAX_HOLD is ignored.

Decomposition:
- Package team_08_gpio_pkg:
  - state enum arb_state_t {IDLE, GRANT, TURN}.
  - GPIO_WIDTH=34.
  - Default IDLE_VAL.
- Sub-module team_08_rr_pick:
  - Parameter NREQ; inputs req and ptr; outputs any and idx.
  - Purely combinational, reused for the pointer-rotated search.

Test Plan:
- Reset mid-GRANT (req0 high, data 34'h2AAAAAAAA): drop reset → gnt=0, gpio_out=0 and busy=0 without waiting for a clock; after release, req0 is regranted 1 cycle later.
- req0 alone with data 34'h155: gnt=0001 at edge 1, gpio_out=34'h155 at edge 2; drop req0 → TURN with gpio_out=0, then IDLE.
- Round-robin: req0..req3 all held high, each releasing after 3 cycles → grant order 0,1,2,3,0, with exactly one gnt-low cycle between owners.
- Timeout (macro on, MAX_HOLD=8): req1 granted, req2 raised → after 8 GRANT cycles preempted=1 for one cycle, then gnt=0100 after TURN. Same run with req2 low → no preempt.
- Macro off, same stimulus → req1 holds 50 cycles; preempted stays 0.
- gpio_in toggled 34'h0→34'h3FFFFFFFF → in_sync changes exactly 2 cycles later.

Source files
------------

// File: rtl/team_08_gpio_pkg.sv
// Shared types and constants for the team 08 GPIO output-bus arbiter.
package team_08_gpio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int GPIO_WIDTH = 34;
    localparam logic [GPIO_WIDTH-1:0] DEFAULT_IDLE_VAL = '0;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/team_08_gpio_arbiter_if.sv
// Requester-side bus of the GPIO arbiter; the arbiter uses the slave modport.
// Handshake: a requester holds req high for its whole ownership; gnt is one-hot or zero.
interface team_08_gpio_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = team_08_gpio_pkg::GPIO_WIDTH
);
    import team_08_gpio_pkg::*;

    localparam int OW = idx_width(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic                  preempted;
    logic [WIDTH-1:0]      gpio_out;
    logic [WIDTH-1:0]      gpio_in;
    logic [WIDTH-1:0]      in_sync;
    arb_state_t            state;

    modport slave (
        input  req, req_data, gpio_in,
        output gnt, owner, busy, preempted, gpio_out, in_sync, state
    );

    modport master (
        output req, req_data, gpio_in,
        input  gnt, owner, busy, preempted, gpio_out, in_sync, state
    );

endinterface

// File: rtl/team_08_gpio_arbiter_rr_pick.sv
// Round-robin picker: first asserted req at or above ptr, wrapping to 0.
module team_08_rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = team_08_gpio_pkg::idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        any = |req;
        idx = '0;
        j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) idx = IW'(j);
        end
    end

endmodule

// File: rtl/team_08_gpio_arbiter.sv
// Round-robin owner of the shared GPIO output bus with 2-flop input synchroniser.
// Optional MAX_HOLD preemption is enabled by defining TEAM08_GPIO_ARB_TIMEOUT_EN.
module team_08_gpio_arbiter
    import team_08_gpio_pkg::*;
#(
    parameter int               NREQ     = 4,
    parameter int               WIDTH    = GPIO_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_VAL = DEFAULT_IDLE_VAL,
    parameter int               MAX_HOLD = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    team_08_gpio_arbiter_if.slave bus
);

    localparam int OW = idx_width(NREQ);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] gpio_q, gpio_d;
    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    logic             pick_any;
    logic [OW-1:0]    pick_idx;
    logic [OW-1:0]    next_ptr;
    logic [WIDTH-1:0] owner_word;
    logic             owner_req;
    logic             others_req;
    logic             hold_expired;

    team_08_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        owner_word = IDLE_VAL;
        owner_req  = 1'b0;
        others_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_word = bus.req_data[i*WIDTH +: WIDTH];
                owner_req  = bus.req[i];
            end else if (bus.req[i]) begin
                others_req = 1'b1;
            end
        end
    end

    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef TEAM08_GPIO_ARB_TIMEOUT_EN
    localparam int            HW        = idx_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          pre_q, pre_d;

    assign hold_expired = (hold_q == HOLD_LAST) && others_req;

    // Counter restarts on every grant edge and saturates while the owner stays.
    always_comb begin
        hold_d = hold_q;
        if (state_q != GRANT)        hold_d = '0;
        else if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        pre_d = (state_q == GRANT) && owner_req && hold_expired;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            pre_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            pre_q  <= pre_d;
        end
    end

    assign bus.preempted = pre_q;
`else
    assign hold_expired  = 1'b0;
    assign bus.preempted = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        gpio_d  = IDLE_VAL;
        unique case (state_q)
            IDLE, TURN: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req || hold_expired) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr;
                end else begin
                    gpio_d = owner_word;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        sync1_d = bus.gpio_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            gpio_q  <= IDLE_VAL;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            gpio_q  <= gpio_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
    assign bus.gpio_out = gpio_q;
    assign bus.in_sync  = sync2_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_team_08_gpio_arbiter.sv
// Self-checking bench for team_08_gpio_arbiter: directed scenarios plus a
// randomized run against a cycle-level ownership model.
module tb_team_08_gpio_arbiter;
    import team_08_gpio_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 34;
    localparam int MAXH = 8;
`ifdef TEAM08_GPIO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    team_08_gpio_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

    team_08_gpio_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (W),
        .IDLE_VAL ({W{1'b0}}),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_data(input int i, input logic [W-1:0] v);
        bus.req_data[i*W +: W] = v;
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.req_data = '0;
        bus.gpio_in  = '0;
        reset        = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_data = '0; bus.gpio_in = '0;
        reset = 1'b0;
        #12;
        tests_run++; if (bus.gnt !== 4'b0) begin tests_failed++; $display("FAIL rst_gnt got %b want 0000", bus.gnt); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        tests_run++; if (bus.preempted !== 1'b0) begin tests_failed++; $display("FAIL rst_pre got %b want 0", bus.preempted); end
        tests_run++; if (bus.owner !== 2'd0) begin tests_failed++; $display("FAIL rst_owner got %0d want 0", bus.owner); end
        tests_run++; if (bus.gpio_out !== 34'h0) begin tests_failed++; $display("FAIL rst_gpio got %h want 0", bus.gpio_out); end
        tests_run++; if (bus.in_sync !== 34'h0) begin tests_failed++; $display("FAIL rst_sync got %h want 0", bus.in_sync); end
        tests_run++; if (bus.state !== IDLE) begin tests_failed++; $display("FAIL rst_state got %0d want IDLE", bus.state); end
        // Reset arriving in the middle of an ownership.
        @(negedge clk); reset = 1'b1;
        bus.req = 4'b0001; set_data(0, 34'h2AAAAAAAA);
        repeat (3) @(negedge clk);
        tests_run++; if (bus.gpio_out !== 34'h2AAAAAAAA) begin tests_failed++; $display("FAIL midrst_pre_gpio got %h want 2aaaaaaaa", bus.gpio_out); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if (bus.gnt !== 4'b0) begin tests_failed++; $display("FAIL midrst_gnt got %b want 0000", bus.gnt); end
        tests_run++; if (bus.gpio_out !== 34'h0) begin tests_failed++; $display("FAIL midrst_gpio got %h want 0", bus.gpio_out); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.gnt !== 4'b0001) begin tests_failed++; $display("FAIL midrst_regrant got %b want 0001", bus.gnt); end
        tests_run++; if (bus.state !== GRANT) begin tests_failed++; $display("FAIL midrst_state got %0d want GRANT", bus.state); end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001; set_data(0, 34'h155);
        @(negedge clk);
        tests_run++; if (bus.gnt !== 4'b0001) begin tests_failed++; $display("FAIL single_gnt got %b want 0001", bus.gnt); end
        tests_run++; if (bus.gpio_out !== 34'h0) begin tests_failed++; $display("FAIL single_gpio_e1 got %h want 0", bus.gpio_out); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy got %b want 1", bus.busy); end
        @(negedge clk);
        tests_run++; if (bus.gpio_out !== 34'h155) begin tests_failed++; $display("FAIL single_gpio_e2 got %h want 155", bus.gpio_out); end
        bus.req = 4'b0000;
        @(negedge clk);
        tests_run++; if (bus.state !== TURN) begin tests_failed++; $display("FAIL single_turn got %0d want TURN", bus.state); end
        tests_run++; if (bus.gnt !== 4'b0) begin tests_failed++; $display("FAIL single_turn_gnt got %b want 0000", bus.gnt); end
        tests_run++; if (bus.gpio_out !== 34'h0) begin tests_failed++; $display("FAIL single_turn_gpio got %h want 0", bus.gpio_out); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL single_turn_busy got %b want 0", bus.busy); end
        @(negedge clk);
        tests_run++; if (bus.state !== IDLE) begin tests_failed++; $display("FAIL single_idle got %0d want IDLE", bus.state); end
        tests_run++; if (bus.owner !== 2'd0) begin tests_failed++; $display("FAIL single_owner got %0d want 0", bus.owner); end
    endtask

    task automatic test_round_robin();
        int          cnt[NREQ];
        int          order[$];
        int          gaps[$];
        int          gap;
        int          want[5];
        logic [3:0]  g, prev;
        do_reset();
        want = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        gap = 0; prev = '0;
        bus.req = 4'hF;
        for (int cyc = 0; cyc < 60 && order.size() < 5; cyc++) begin
            @(negedge clk);
            g = bus.gnt;
            tests_run++; if (!$onehot0(g)) begin tests_failed++; $display("FAIL rr_onehot got %b want one-hot or zero", g); end
            if (g != 0 && prev == 0) begin
                for (int i = 0; i < NREQ; i++) if (g[i]) order.push_back(i);
                if (order.size() > 1) gaps.push_back(gap);
                gap = 0;
            end
            if (g == 0 && order.size() > 0) gap++;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin bus.req[i] = 1'b0; cnt[i] = 0; end
                end else if (!bus.req[i]) begin
                    bus.req[i] = 1'b1;
                end
            end
            prev = g;
        end
        bus.req = '0;
        tests_run++; if (order.size() != 5) begin tests_failed++; $display("FAIL rr_count got %0d grants want 5", order.size()); end
        for (int i = 0; i < order.size() && i < 5; i++) begin
            tests_run++; if (order[i] != want[i]) begin tests_failed++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], want[i]); end
        end
        foreach (gaps[i]) begin
            tests_run++; if (gaps[i] != 1) begin tests_failed++; $display("FAIL rr_gap[%0d] got %0d want 1", i, gaps[i]); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold();
        do_reset();
        bus.req = 4'b0010; set_data(1, 34'h111); set_data(2, 34'h222);
        @(negedge clk);
        tests_run++; if (bus.gnt !== 4'b0010) begin tests_failed++; $display("FAIL hold_gnt1 got %b want 0010", bus.gnt); end
        bus.req = 4'b0110;
`ifdef TEAM08_GPIO_ARB_TIMEOUT_EN
        for (int k = 2; k <= MAXH; k++) begin
            @(negedge clk);
            tests_run++; if (bus.gnt !== 4'b0010) begin tests_failed++; $display("FAIL hold_keep[%0d] got %b want 0010", k, bus.gnt); end
            tests_run++; if (bus.preempted !== 1'b0) begin tests_failed++; $display("FAIL hold_nopre[%0d] got %b want 0", k, bus.preempted); end
        end
        @(negedge clk);
        tests_run++; if (bus.preempted !== 1'b1) begin tests_failed++; $display("FAIL hold_pre got %b want 1", bus.preempted); end
        tests_run++; if (bus.gnt !== 4'b0) begin tests_failed++; $display("FAIL hold_pre_gnt got %b want 0000", bus.gnt); end
        tests_run++; if (bus.state !== TURN) begin tests_failed++; $display("FAIL hold_pre_state got %0d want TURN", bus.state); end
        @(negedge clk);
        tests_run++; if (bus.gnt !== 4'b0100) begin tests_failed++; $display("FAIL hold_next got %b want 0100", bus.gnt); end
        tests_run++; if (bus.preempted !== 1'b0) begin tests_failed++; $display("FAIL hold_pre_pulse got %b want 0", bus.preempted); end
        // Alone on the bus: saturated counter must not release the owner.
        do_reset();
        bus.req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests_run++; if (bus.gnt !== 4'b0010 || bus.preempted !== 1'b0) begin tests_failed++; $display("FAIL hold_alone[%0d] got gnt=%b pre=%b want 0010/0", k, bus.gnt, bus.preempted); end
        end
`else
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            tests_run++; if (bus.gnt !== 4'b0010 || bus.preempted !== 1'b0) begin tests_failed++; $display("FAIL hold_keep[%0d] got gnt=%b pre=%b want 0010/0", k, bus.gnt, bus.preempted); end
        end
`endif
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sync();
        bus.gpio_in = 34'h0;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.in_sync !== 34'h0) begin tests_failed++; $display("FAIL sync_zero got %h want 0", bus.in_sync); end
        bus.gpio_in = 34'h3FFFFFFFF;
        @(negedge clk);
        tests_run++; if (bus.in_sync !== 34'h0) begin tests_failed++; $display("FAIL sync_lat1 got %h want 0", bus.in_sync); end
        @(negedge clk);
        tests_run++; if (bus.in_sync !== 34'h3FFFFFFFF) begin tests_failed++; $display("FAIL sync_lat2 got %h want 3ffffffff", bus.in_sync); end
        bus.gpio_in = 34'h0;
        @(negedge clk);
        tests_run++; if (bus.in_sync !== 34'h3FFFFFFFF) begin tests_failed++; $display("FAIL sync_back1 got %h want 3ffffffff", bus.in_sync); end
        @(negedge clk);
        tests_run++; if (bus.in_sync !== 34'h0) begin tests_failed++; $display("FAIL sync_back2 got %h want 0", bus.in_sync); end
    endtask

    task automatic test_random();
        int          m_owner, m_last, m_ptr, m_held;
        bit          m_turn, others;
        logic [W-1:0] e_gpio, e_sync, m_s1, gin;
        logic        e_pre;
        logic [3:0]  r, e_gnt;
        logic [W-1:0] d[NREQ];
        arb_state_t  e_state;
        do_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_turn = 0;
        e_gpio = '0; e_sync = '0; m_s1 = '0; e_pre = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // New inputs, stable across the coming edge.
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r = '0;
            if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 5) != 0);
            for (int i = 0; i < NREQ; i++) begin
                d[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
                set_data(i, d[i]);
            end
            gin = {2'($urandom_range(0, 3)), 32'($urandom)};
            bus.req = r; bus.gpio_in = gin;
            // Ownership model for the edge.
            e_sync = m_s1; m_s1 = gin;
            e_pre = 1'b0; e_gpio = '0;
            if (m_owner >= 0) begin
                others = (r & ~(4'b1 << m_owner)) != 0;
                if (!r[m_owner] || (TO_EN && m_held == MAXH - 1 && others)) begin
                    e_pre = TO_EN && r[m_owner];
                    m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_turn = 1;
                end else begin
                    e_gpio = d[m_owner];
                    if (m_held < MAXH - 1) m_held++;
                end
            end else begin
                m_turn = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (m_owner < 0 && r[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ; m_last = m_owner; m_held = 0;
                    end
                end
            end
            e_gnt   = (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0;
            e_state = (m_owner >= 0) ? GRANT : (m_turn ? TURN : IDLE);
            @(negedge clk);
            tests_run++; if (bus.gnt !== e_gnt) begin tests_failed++; $display("FAIL rnd_gnt@%0d got %b want %b", cyc, bus.gnt, e_gnt); end
            tests_run++; if (bus.gpio_out !== e_gpio) begin tests_failed++; $display("FAIL rnd_gpio@%0d got %h want %h", cyc, bus.gpio_out, e_gpio); end
            tests_run++; if (bus.busy !== (m_owner >= 0)) begin tests_failed++; $display("FAIL rnd_busy@%0d got %b want %b", cyc, bus.busy, m_owner >= 0); end
            tests_run++; if (bus.owner !== 2'(m_last)) begin tests_failed++; $display("FAIL rnd_owner@%0d got %0d want %0d", cyc, bus.owner, m_last); end
            tests_run++; if (bus.preempted !== e_pre) begin tests_failed++; $display("FAIL rnd_pre@%0d got %b want %b", cyc, bus.preempted, e_pre); end
            tests_run++; if (bus.state !== e_state) begin tests_failed++; $display("FAIL rnd_state@%0d got %0d want %0d", cyc, bus.state, e_state); end
            tests_run++; if (bus.in_sync !== e_sync) begin tests_failed++; $display("FAIL rnd_sync@%0d got %h want %h", cyc, bus.in_sync, e_sync); end
        end
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_sync();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
